// File: rtl/fetch_queue_pkg.sv
// ----------------------------------------------------------------------------
// fetch_queue_pkg
// Shared types for the frontend -> rename decoupling queue.
//   decode_data : one decoded instruction as handed from decode to rename
//   FQ_DEPTH    : queue depth used by the processor top
// ----------------------------------------------------------------------------
package fetch_queue_pkg;

    localparam int FQ_DEPTH = 8;

    // One decoded instruction; pc travels with it so rename/ROB can recover.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic        rd_valid;
    } decode_data;

endpackage : fetch_queue_pkg

// File: rtl/fetch_queue_if.sv
// ----------------------------------------------------------------------------
// fetch_queue_if
// Valid/ready stream carrying decode_data.
//   valid : producer offers data this cycle
//   data  : decoded instruction
//   ready : consumer accepts data this cycle
// Modports:
//   master : producer side (drives valid/data, observes ready)
//   slave  : consumer side (observes valid/data, drives ready)
// ----------------------------------------------------------------------------
interface fetch_queue_if;
    import fetch_queue_pkg::*;

    logic       valid;
    decode_data data;
    logic       ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface : fetch_queue_if

// File: rtl/fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue
// Decoupling FIFO between fetch/decode and rename. Absorbs decode bandwidth
// while rename is stalled, keeps rename's ready off the frontend's
// combinational path, and empties itself on a branch mispredict.
//
// Ports:
//   clk        : clock, all state on posedge
//   reset      : asynchronous active-high reset
//   push_port  : slave stream from the frontend
//                  valid = valid_in, data = data_in, ready = ready_out
//   pop_port   : master stream to rename
//                  valid = valid_out, data = data_out (first-word
//                  fall-through), ready = ready_in
//   mispredict : ROB flush request, level sensitive
//   count      : current occupancy 0..DEPTH
//   full       : count == DEPTH
//   empty      : count == 0
// ----------------------------------------------------------------------------
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter  int DEPTH = FQ_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    fetch_queue_if.slave     push_port,
    fetch_queue_if.master    pop_port,
    input  logic             mispredict,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // without consulting the occupancy counter.
    logic [PTR_W:0]   head;
    logic [PTR_W:0]   tail;
    logic [CNT_W-1:0] count_q;
    decode_data       mem [DEPTH];

    logic [PTR_W-1:0] head_idx;
    logic [PTR_W-1:0] tail_idx;
    logic             ptr_full;
    logic             ptr_empty;
    logic             push;
    logic             pop;

    assign head_idx  = head[PTR_W-1:0];
    assign tail_idx  = tail[PTR_W-1:0];
    assign ptr_empty = (head == tail);
    assign ptr_full  = (head_idx == tail_idx) && (head[PTR_W] != tail[PTR_W]);

    // ready_out looks only at registered state and mispredict so that rename
    // back-pressure never reaches the frontend combinationally. A pop in the
    // same cycle does not free a slot for a push while full.
    assign push_port.ready = !ptr_full && !mispredict;
    assign pop_port.valid  = !ptr_empty && !mispredict;
    assign pop_port.data   = mem[head_idx];

    assign push = push_port.valid && push_port.ready;
    assign pop  = pop_port.valid && pop_port.ready;

    assign count = count_q;
    assign full  = ptr_full;
    assign empty = ptr_empty;

    // Pointer and occupancy state. A mispredict wins over everything and
    // collapses the queue to the empty, zero-pointer state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else if (mispredict) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Storage is not reset; entries are only visible between head and tail.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail_idx] <= push_port.data;
        end
    end

    // The separate counter must always agree with the pointer distance.
    count_matches_ptrs : assert property (
        @(posedge clk) disable iff (reset) count_q == CNT_W'(tail - head)
    );

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// ----------------------------------------------------------------------------
// tb_fetch_queue
// Self-checking bench for fetch_queue. A queue-based reference model follows
// the FIFO rules and a negedge compare process checks every visible output
// against it; directed scenarios add literal expectations on top.
// ----------------------------------------------------------------------------
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = FQ_DEPTH;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       mispredict = 1'b0;
    logic [3:0] count;
    logic       full;
    logic       empty;

    int checks   = 0;
    int failures = 0;

    fetch_queue_if fe_if ();
    fetch_queue_if rn_if ();

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .push_port  (fe_if),
        .pop_port   (rn_if),
        .mispredict (mispredict),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    // Reference model: contents in order, plus the log of everything popped.
    decode_data  model_q [$];
    logic [31:0] popped  [$];

    function automatic decode_data makeData(input logic [31:0] pc);
        decode_data d;
        d.pc       = pc;
        d.inst     = pc ^ 32'hDEAD_0000;
        d.rd       = pc[6:2];
        d.rd_valid = pc[2];
        return d;
    endfunction

    function automatic void checkOutput(input string name, input logic [63:0] actual,
                                        input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endfunction

    // Model update: acceptance is decided from the occupancy before the edge,
    // so a full queue refuses a push even when a pop happens.
    always @(posedge clk or posedge reset) begin
        bit do_push;
        bit do_pop;
        if (reset) begin
            model_q.delete();
        end else if (mispredict) begin
            model_q.delete();
        end else begin
            do_pop  = rn_if.ready && (model_q.size() > 0);
            do_push = fe_if.valid && (model_q.size() < DEPTH);
            if (do_pop) begin
                popped.push_back(model_q[0].pc);
                void'(model_q.pop_front());
            end
            if (do_push) begin
                model_q.push_back(fe_if.data);
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        int sz;
        if (!reset) begin
            sz = model_q.size();
            checkOutput("count",     64'(count),       64'(sz));
            checkOutput("empty",     64'(empty),       64'(sz == 0));
            checkOutput("full",      64'(full),        64'(sz == DEPTH));
            checkOutput("ready_out", 64'(fe_if.ready), 64'((sz < DEPTH) && !mispredict));
            checkOutput("valid_out", 64'(rn_if.valid), 64'((sz > 0) && !mispredict));
            if (sz > 0 && !mispredict) begin
                checkOutput("data_out.pc",   64'(rn_if.data.pc),   64'(model_q[0].pc));
                checkOutput("data_out.inst", 64'(rn_if.data.inst), 64'(model_q[0].inst));
            end
        end
    end

    // Drive one cycle's inputs just after the active edge.
    task automatic applyStimulus(input logic v, input logic [31:0] pc,
                                 input logic r, input logic m);
        @(posedge clk);
        #1;
        fe_if.valid = v;
        fe_if.data  = makeData(pc);
        rn_if.ready = r;
        mispredict  = m;
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        fe_if.valid = 1'b0;
        rn_if.ready = 1'b0;
        mispredict  = 1'b0;
        reset       = 1'b1;
        #3;
        reset = 1'b0;
        popped.delete();
    endtask

    initial begin
        fe_if.valid = 1'b0;
        fe_if.data  = makeData(32'h0);
        rn_if.ready = 1'b0;
        #12;
        checkOutput("reset ready_out", 64'(fe_if.ready), 64'd1);
        checkOutput("reset valid_out", 64'(rn_if.valid), 64'd0);
        checkOutput("reset empty",     64'(empty),       64'd1);
        checkOutput("reset count",     64'(count),       64'd0);
        reset = 1'b0;

        // Scenario 1: three pushes, then drain in order.
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 32'(4 * k), 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("s1 count",   64'(count),          64'd3);
        checkOutput("s1 valid",   64'(rn_if.valid),    64'd1);
        checkOutput("s1 head pc", 64'(rn_if.data.pc),  64'd0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("s1 empty",     64'(empty),         64'd1);
        checkOutput("s1 pop count", 64'(popped.size()), 64'd3);
        for (int k = 0; k < 3 && k < popped.size(); k++)
            checkOutput("s1 pop order", 64'(popped[k]), 64'(4 * k));

        // Scenario 2: fill to full, a ninth push is dropped, drain eight.
        doReset();
        for (int k = 0; k < 8; k++) applyStimulus(1'b1, 32'h100 + 32'(4 * k), 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h999, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("s2 full",      64'(full),        64'd1);
        checkOutput("s2 ready_out", 64'(fe_if.ready), 64'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("s2 count after drop", 64'(count), 64'd8);
        for (int k = 0; k < 10; k++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("s2 empty",     64'(empty),         64'd1);
        checkOutput("s2 pop count", 64'(popped.size()), 64'd8);
        for (int k = 0; k < 8 && k < popped.size(); k++)
            checkOutput("s2 pop order", 64'(popped[k]), 64'(32'h100 + 32'(4 * k)));

        // Scenario 3: steady push+pop at occupancy four, pointers wrap.
        doReset();
        for (int k = 0; k < 4; k++) applyStimulus(1'b1, 32'h300 + 32'(4 * k), 1'b0, 1'b0);
        for (int k = 4; k < 24; k++) applyStimulus(1'b1, 32'h300 + 32'(4 * k), 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("s3 count",     64'(count),         64'd4);
        checkOutput("s3 head pc",   64'(rn_if.data.pc), 64'h350);
        checkOutput("s3 pop count", 64'(popped.size()), 64'd20);
        for (int k = 0; k < 20 && k < popped.size(); k++)
            checkOutput("s3 pop order", 64'(popped[k]), 64'(32'h300 + 32'(4 * k)));

        // Scenario 4: mispredict at occupancy five.
        doReset();
        for (int k = 0; k < 5; k++) applyStimulus(1'b1, 32'h200 + 32'(4 * k), 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h500, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("s4 flush valid_out", 64'(rn_if.valid), 64'd0);
        checkOutput("s4 flush ready_out", 64'(fe_if.ready), 64'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("s4 count", 64'(count),         64'd0);
        checkOutput("s4 empty", 64'(empty),         64'd1);
        checkOutput("s4 no pop", 64'(popped.size()), 64'd0);
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("s4 valid after flush", 64'(rn_if.valid),   64'd1);
        checkOutput("s4 pc after flush",    64'(rn_if.data.pc), 64'h40);

        // Scenario 5: asynchronous reset mid-cycle at occupancy six.
        doReset();
        for (int k = 0; k < 6; k++) applyStimulus(1'b1, 32'h600 + 32'(4 * k), 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("s5 count before", 64'(count), 64'd6);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("s5 async count",     64'(count),       64'd0);
        checkOutput("s5 async valid_out", 64'(rn_if.valid), 64'd0);
        checkOutput("s5 async ready_out", 64'(fe_if.ready), 64'd1);
        checkOutput("s5 async empty",     64'(empty),       64'd1);
        #1;
        reset = 1'b0;

        // Scenario 6: random traffic with occasional flushes.
        popped.delete();
        for (int k = 0; k < 10000; k++) begin
            applyStimulus(1'($urandom_range(0, 1)), 32'h1000 + 32'(4 * k),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 49) == 0));
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fetch_queue
